// File: rtl/gol_bank_sched_pkg.sv
// Shared types and defaults for the Game-of-Life bank scheduler.
// Holds the scheduler state encoding, default widths and the swap-divider test.
package gol_bank_sched_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 4;
  localparam int LATE_W     = 16;
  localparam int DIV_W      = 8;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2,
    ST_READY = 2'd3
  } sched_state_t;

  // True once enough SOFs have passed since the last swap to allow another one.
  function automatic logic div_expired(input logic [DIV_W-1:0] cnt, input int frame_div);
    return int'(cnt) >= (frame_div - 1);
  endfunction

endpackage

// File: rtl/gol_bank_sched_port_mux.sv
// Per-bank port steering: picks address, write enable and write data for one gol_ram
// bank from its current role (display or back) and whether the system is initialising.
module gol_bank_sched_port_mux
  import gol_bank_sched_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              is_display,
  input  logic              init_mode,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  input  logic [ADDR_W-1:0] eng_rd_addr,
  input  logic              eng_wr_req,
  input  logic [ADDR_W-1:0] eng_wr_addr,
  input  logic [DATA_W-1:0] eng_wr_data,
  output logic [ADDR_W-1:0] addr,
  output logic              we,
  output logic [DATA_W-1:0] din
);

  // NOTE: every output gets a default first so no path through this block infers a latch.
  always_comb begin
    addr = eng_wr_addr;
    we   = 1'b0;
    din  = eng_wr_data;
    if (init_mode) begin
      // Init writes land in both banks; on the display bank a write takes the
      // single port and a coincident video read returns that address instead.
      we = eng_wr_req;
      if (is_display && !eng_wr_req) addr = vid_addr;
    end else if (is_display) begin
      addr = vid_req ? vid_addr : eng_rd_addr;
    end else begin
      we = eng_wr_req;
    end
  end

endmodule

// File: rtl/gol_bank_sched.sv
// Double-buffered bank scheduler: video and engine read the display bank, the engine
// writes the back bank, and banks swap at SOF once a generation has completed.
module gol_bank_sched
  import gol_bank_sched_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int FRAME_DIV = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              video_sof,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_valid,
  output logic [DATA_W-1:0] vid_data,
  input  logic              init_done,
  output logic              eng_start,
  input  logic              eng_gen_done,
  input  logic              eng_rd_req,
  input  logic [ADDR_W-1:0] eng_rd_addr,
  output logic              eng_rd_gnt,
  output logic              eng_rd_valid,
  output logic [DATA_W-1:0] eng_rd_data,
  input  logic              eng_wr_req,
  input  logic [ADDR_W-1:0] eng_wr_addr,
  input  logic [DATA_W-1:0] eng_wr_data,
  output logic [ADDR_W-1:0] ram0_addr,
  output logic              ram0_we,
  output logic [DATA_W-1:0] ram0_din,
  input  logic [DATA_W-1:0] ram0_dout,
  output logic [ADDR_W-1:0] ram1_addr,
  output logic              ram1_we,
  output logic [DATA_W-1:0] ram1_din,
  input  logic [DATA_W-1:0] ram1_dout,
  output logic              display_bank,
  output logic [LATE_W-1:0] late_cnt
);

  sched_state_t      state, state_nx;
  logic              display_bank_nx;
  logic [LATE_W-1:0] late_nx;
  logic [DIV_W-1:0]  div_cnt, div_nx;
  logic              start_nx;
  logic              init_mode;
  logic              gen_ready;
  logic              rd_vid_q, rd_eng_q, rd_bank_q;
  logic [DATA_W-1:0] rd_data;

  assign init_mode  = (state == ST_INIT);
  assign gen_ready  = (state == ST_READY) || eng_gen_done;
  assign eng_rd_gnt = eng_rd_req && !vid_req && (state == ST_RUN || state == ST_READY);

  always_comb begin
    state_nx        = state;
    display_bank_nx = display_bank;
    late_nx         = late_cnt;
    div_nx          = div_cnt;
    start_nx        = 1'b0;
    unique case (state)
      ST_INIT: begin
        if (init_done) state_nx = ST_PRIME;
      end
      ST_PRIME: begin
        if (video_sof) begin
          state_nx = ST_RUN;
          start_nx = 1'b1;
          div_nx   = '0;
        end
      end
      ST_RUN, ST_READY: begin
        if (video_sof) begin
          if (gen_ready && div_expired(div_cnt, FRAME_DIV)) begin
            display_bank_nx = !display_bank;
            start_nx        = 1'b1;
            div_nx          = '0;
            state_nx        = ST_RUN;
          end else begin
            // Deferred swap: the divider keeps counting; only an unfinished generation is late.
            if (div_cnt != '1) div_nx = div_cnt + DIV_W'(1);
            if (!gen_ready && late_cnt != '1) late_nx = late_cnt + LATE_W'(1);
            state_nx = gen_ready ? ST_READY : ST_RUN;
          end
        end else if (eng_gen_done) begin
          state_nx = ST_READY;
        end
      end
      default: state_nx = ST_INIT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_INIT;
      display_bank <= 1'b0;
      late_cnt     <= '0;
      div_cnt      <= '0;
      eng_start    <= 1'b0;
      rd_vid_q     <= 1'b0;
      rd_eng_q     <= 1'b0;
      rd_bank_q    <= 1'b0;
    end else begin
      state        <= state_nx;
      display_bank <= display_bank_nx;
      late_cnt     <= late_nx;
      div_cnt      <= div_nx;
      eng_start    <= start_nx;
      rd_vid_q     <= vid_req;
      rd_eng_q     <= eng_rd_gnt;
      // Remember which bank each read went to so a swap cannot redirect in-flight data.
      rd_bank_q    <= display_bank;
    end
  end

  assign rd_data      = rd_bank_q ? ram1_dout : ram0_dout;
  assign vid_valid    = rd_vid_q;
  assign vid_data     = rd_data;
  assign eng_rd_valid = rd_eng_q;
  assign eng_rd_data  = rd_data;

  gol_bank_sched_port_mux #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_mux0 (
    .is_display  (!display_bank),
    .init_mode   (init_mode),
    .vid_req     (vid_req),
    .vid_addr    (vid_addr),
    .eng_rd_addr (eng_rd_addr),
    .eng_wr_req  (eng_wr_req),
    .eng_wr_addr (eng_wr_addr),
    .eng_wr_data (eng_wr_data),
    .addr        (ram0_addr),
    .we          (ram0_we),
    .din         (ram0_din)
  );

  gol_bank_sched_port_mux #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_mux1 (
    .is_display  (display_bank),
    .init_mode   (init_mode),
    .vid_req     (vid_req),
    .vid_addr    (vid_addr),
    .eng_rd_addr (eng_rd_addr),
    .eng_wr_req  (eng_wr_req),
    .eng_wr_addr (eng_wr_addr),
    .eng_wr_data (eng_wr_data),
    .addr        (ram1_addr),
    .we          (ram1_we),
    .din         (ram1_din)
  );

endmodule

// File: tb/tb_gol_bank_sched.sv
// Directed bench for gol_bank_sched: two DUTs (FRAME_DIV=1 and 3) with behavioural
// banks, a table of arbitration vectors and hand-written swap/late/reset sequences.
`timescale 1ns/1ps
module tb_gol_bank_sched;

  logic        clk = 1'b0;
  logic        rst, rst3;
  logic        video_sof, vid_req, init_done, eng_gen_done;
  logic        eng_rd_req, eng_wr_req;
  logic [15:0] vid_addr, eng_rd_addr, eng_wr_addr;
  logic [3:0]  eng_wr_data;

  logic        vid_valid, eng_start, eng_rd_gnt, eng_rd_valid, display_bank;
  logic [3:0]  vid_data, eng_rd_data, ram0_din, ram1_din;
  logic [3:0]  ram0_dout, ram1_dout;
  logic [15:0] ram0_addr, ram1_addr, late_cnt;
  logic        ram0_we, ram1_we;

  logic        vid_valid_3, eng_start_3, eng_rd_gnt_3, eng_rd_valid_3, display_bank_3;
  logic [3:0]  vid_data_3, eng_rd_data_3, ram0_din_3, ram1_din_3;
  logic [15:0] ram0_addr_3, ram1_addr_3, late_cnt_3;
  logic        ram0_we_3, ram1_we_3;
  logic [3:0]  zero_dout = 4'h0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  gol_bank_sched #(.ADDR_W(16), .DATA_W(4), .FRAME_DIV(1)) dut (
    .clk(clk), .rst(rst), .video_sof(video_sof),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_valid(vid_valid), .vid_data(vid_data),
    .init_done(init_done), .eng_start(eng_start), .eng_gen_done(eng_gen_done),
    .eng_rd_req(eng_rd_req), .eng_rd_addr(eng_rd_addr), .eng_rd_gnt(eng_rd_gnt),
    .eng_rd_valid(eng_rd_valid), .eng_rd_data(eng_rd_data),
    .eng_wr_req(eng_wr_req), .eng_wr_addr(eng_wr_addr), .eng_wr_data(eng_wr_data),
    .ram0_addr(ram0_addr), .ram0_we(ram0_we), .ram0_din(ram0_din), .ram0_dout(ram0_dout),
    .ram1_addr(ram1_addr), .ram1_we(ram1_we), .ram1_din(ram1_din), .ram1_dout(ram1_dout),
    .display_bank(display_bank), .late_cnt(late_cnt)
  );

  gol_bank_sched #(.ADDR_W(16), .DATA_W(4), .FRAME_DIV(3)) dut3 (
    .clk(clk), .rst(rst3), .video_sof(video_sof),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_valid(vid_valid_3), .vid_data(vid_data_3),
    .init_done(init_done), .eng_start(eng_start_3), .eng_gen_done(eng_gen_done),
    .eng_rd_req(eng_rd_req), .eng_rd_addr(eng_rd_addr), .eng_rd_gnt(eng_rd_gnt_3),
    .eng_rd_valid(eng_rd_valid_3), .eng_rd_data(eng_rd_data_3),
    .eng_wr_req(eng_wr_req), .eng_wr_addr(eng_wr_addr), .eng_wr_data(eng_wr_data),
    .ram0_addr(ram0_addr_3), .ram0_we(ram0_we_3), .ram0_din(ram0_din_3), .ram0_dout(zero_dout),
    .ram1_addr(ram1_addr_3), .ram1_we(ram1_we_3), .ram1_din(ram1_din_3), .ram1_dout(zero_dout),
    .display_bank(display_bank_3), .late_cnt(late_cnt_3)
  );

  // Behavioural banks with 1-cycle synchronous read; bank0 holds addr[3:0], bank1 its inverse.
  logic [3:0] mem0 [0:65535];
  logic [3:0] mem1 [0:65535];

  // NOTE: memories are never reset; they are preloaded once so read data is predictable.
  initial begin
    for (int i = 0; i < 65536; i++) begin
      mem0[i] = i[3:0];
      mem1[i] = ~i[3:0];
    end
  end

  always @(posedge clk) begin
    if (ram0_we) mem0[ram0_addr] <= ram0_din;
    if (ram1_we) mem1[ram1_addr] <= ram1_din;
    ram0_dout <= mem0[ram0_addr];
    ram1_dout <= mem1[ram1_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        vid_req;
    logic [15:0] vid_addr;
    logic        eng_rd_req;
    logic [15:0] eng_rd_addr;
    logic        eng_wr_req;
    logic [15:0] eng_wr_addr;
    logic [3:0]  eng_wr_data;
    logic        exp_gnt;
    logic [15:0] exp_r0_addr;
    logic        exp_r0_we;
    logic [15:0] exp_r1_addr;
    logic        exp_r1_we;
    logic        exp_vv;
    logic        exp_ev;
    logic [3:0]  exp_rd;
  } vec_t;

  vec_t vecs [4];

  initial begin
    // Applied in RUN with display_bank=1: ram1 is display (reads), ram0 is back (writes).
    vecs[0] = '{1'b1, 16'h0105, 1'b0, 16'h0203, 1'b0, 16'h0300, 4'h0,
                1'b0, 16'h0300, 1'b0, 16'h0105, 1'b0, 1'b1, 1'b0, 4'hA};
    vecs[1] = '{1'b0, 16'h0105, 1'b1, 16'h0209, 1'b1, 16'h0301, 4'h7,
                1'b1, 16'h0301, 1'b1, 16'h0209, 1'b0, 1'b0, 1'b1, 4'h6};
    vecs[2] = '{1'b1, 16'h0107, 1'b1, 16'h020B, 1'b1, 16'h0302, 4'h3,
                1'b0, 16'h0302, 1'b1, 16'h0107, 1'b0, 1'b1, 1'b0, 4'h8};
    vecs[3] = '{1'b0, 16'h0107, 1'b1, 16'h020B, 1'b0, 16'h0303, 4'h0,
                1'b1, 16'h0303, 1'b0, 16'h020B, 1'b0, 1'b0, 1'b1, 4'h4};

    rst = 1'b1; rst3 = 1'b1;
    video_sof = 1'b0; vid_req = 1'b0; init_done = 1'b0; eng_gen_done = 1'b0;
    eng_rd_req = 1'b0; eng_wr_req = 1'b0;
    vid_addr = '0; eng_rd_addr = '0; eng_wr_addr = '0; eng_wr_data = '0;

    // Reset: a read issued while in reset must not produce a valid.
    step();
    vid_req = 1'b1;
    step();
    vid_req = 1'b0;
    check("rst_display_bank", display_bank, 0);
    check("rst_late_cnt", late_cnt, 0);
    check("rst_eng_start", eng_start, 0);
    check("rst_vid_valid", vid_valid, 0);
    check("rst_eng_rd_valid", eng_rd_valid, 0);
    rst = 1'b0;

    // INIT: a write reaches both banks; engine reads are not granted.
    eng_wr_req = 1'b1; eng_wr_addr = 16'h1234; eng_wr_data = 4'hA;
    eng_rd_req = 1'b1; eng_rd_addr = 16'h0010;
    #1;
    check("init_ram0_we", ram0_we, 1);
    check("init_ram1_we", ram1_we, 1);
    check("init_ram0_addr", ram0_addr, 16'h1234);
    check("init_ram1_addr", ram1_addr, 16'h1234);
    check("init_ram1_din", ram1_din, 4'hA);
    check("init_eng_rd_gnt", eng_rd_gnt, 0);
    step();
    eng_wr_req = 1'b0; eng_rd_req = 1'b0;
    check("init_mem0", mem0[16'h1234], 4'hA);
    check("init_mem1", mem1[16'h1234], 4'hA);
    check("init_eng_rd_valid", eng_rd_valid, 0);
    vid_req = 1'b1; vid_addr = 16'h1234;
    step();
    vid_req = 1'b0;
    check("init_vid_valid", vid_valid, 1);
    check("init_vid_data", vid_data, 4'hA);

    // PRIME: start pulse the cycle after SOF, no swap.
    init_done = 1'b1;
    step();
    step();
    check("prime_no_start", eng_start, 0);
    video_sof = 1'b1;
    step();
    video_sof = 1'b0;
    check("prime_start", eng_start, 1);
    check("prime_display", display_bank, 0);
    step();
    check("prime_start_pulse", eng_start, 0);

    // Swap: gen_done then SOF.
    eng_gen_done = 1'b1;
    step();
    eng_gen_done = 1'b0;
    check("ready_display", display_bank, 0);
    video_sof = 1'b1;
    step();
    video_sof = 1'b0;
    check("swap_display", display_bank, 1);
    check("swap_start", eng_start, 1);
    check("swap_late", late_cnt, 0);
    step();
    eng_wr_req = 1'b1; eng_wr_addr = 16'h0042; eng_wr_data = 4'h5;
    #1;
    check("back_ram0_we", ram0_we, 1);
    check("back_ram1_we", ram1_we, 0);
    step();
    eng_wr_req = 1'b0;
    check("back_mem0", mem0[16'h0042], 4'h5);
    check("back_mem1_kept", mem1[16'h0042], 4'hD);

    // Arbitration vectors.
    for (int i = 0; i < 4; i++) begin
      vid_req = vecs[i].vid_req; vid_addr = vecs[i].vid_addr;
      eng_rd_req = vecs[i].eng_rd_req; eng_rd_addr = vecs[i].eng_rd_addr;
      eng_wr_req = vecs[i].eng_wr_req; eng_wr_addr = vecs[i].eng_wr_addr;
      eng_wr_data = vecs[i].eng_wr_data;
      #1;
      check($sformatf("vec%0d_gnt", i), eng_rd_gnt, vecs[i].exp_gnt);
      check($sformatf("vec%0d_ram0_addr", i), ram0_addr, vecs[i].exp_r0_addr);
      check($sformatf("vec%0d_ram0_we", i), ram0_we, vecs[i].exp_r0_we);
      check($sformatf("vec%0d_ram1_addr", i), ram1_addr, vecs[i].exp_r1_addr);
      check($sformatf("vec%0d_ram1_we", i), ram1_we, vecs[i].exp_r1_we);
      step();
      check($sformatf("vec%0d_vid_valid", i), vid_valid, vecs[i].exp_vv);
      check($sformatf("vec%0d_eng_rd_valid", i), eng_rd_valid, vecs[i].exp_ev);
      if (vecs[i].exp_vv) check($sformatf("vec%0d_vid_data", i), vid_data, vecs[i].exp_rd);
      if (vecs[i].exp_ev) check($sformatf("vec%0d_eng_rd_data", i), eng_rd_data, vecs[i].exp_rd);
    end
    vid_req = 1'b0; eng_rd_req = 1'b0; eng_wr_req = 1'b0;
    check("vec_back_write", mem0[16'h0301], 4'h7);

    // In-flight read across a swap comes from the bank it was issued to.
    eng_gen_done = 1'b1;
    step();
    eng_gen_done = 1'b0;
    video_sof = 1'b1; vid_req = 1'b1; vid_addr = 16'h0105;
    step();
    video_sof = 1'b0;
    check("steer_display", display_bank, 0);
    check("steer_start", eng_start, 1);
    check("steer_vid_valid", vid_valid, 1);
    check("steer_old_bank_data", vid_data, 4'hA);
    step();
    vid_req = 1'b0;
    check("steer_new_bank_data", vid_data, 4'h5);

    // Late frames: SOF in RUN without gen_done.
    for (int k = 0; k < 3; k++) begin
      video_sof = 1'b1;
      step();
      video_sof = 1'b0;
      step();
    end
    check("late_cnt3", late_cnt, 3);
    check("late_display", display_bank, 0);
    check("late_no_start", eng_start, 0);

    // Same-cycle SOF and gen_done counts as complete.
    video_sof = 1'b1; eng_gen_done = 1'b1;
    step();
    video_sof = 1'b0; eng_gen_done = 1'b0;
    check("same_display", display_bank, 1);
    check("same_start", eng_start, 1);
    check("same_late", late_cnt, 3);

    // FRAME_DIV=3 instance.
    step();
    rst3 = 1'b0;
    step();
    video_sof = 1'b1;
    step();
    video_sof = 1'b0;
    check("fd3_prime_start", eng_start_3, 1);
    eng_gen_done = 1'b1;
    step();
    eng_gen_done = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      video_sof = 1'b1;
      step();
      video_sof = 1'b0;
      check($sformatf("fd3_sof%0d_display", k), display_bank_3, (k == 3) ? 1 : 0);
      check($sformatf("fd3_sof%0d_start", k), eng_start_3, (k == 3) ? 1 : 0);
      check($sformatf("fd3_sof%0d_late", k), late_cnt_3, 0);
      step();
    end
    video_sof = 1'b1;
    step();
    video_sof = 1'b0;
    check("fd3_late", late_cnt_3, 1);

    // Reset mid-RUN drops the in-flight read and restores INIT values.
    vid_req = 1'b1; vid_addr = 16'h0000;
    step();
    rst3 = 1'b1;
    step();
    vid_req = 1'b0;
    check("mrst_vid_valid", vid_valid_3, 0);
    check("mrst_display", display_bank_3, 0);
    check("mrst_late", late_cnt_3, 0);
    check("mrst_start", eng_start_3, 0);
    init_done = 1'b0;
    rst3 = 1'b0;
    eng_wr_req = 1'b1; eng_wr_addr = 16'h0777; eng_wr_data = 4'h9;
    #1;
    check("mrst_init_ram0_we", ram0_we_3, 1);
    check("mrst_init_ram1_we", ram1_we_3, 1);
    step();
    eng_wr_req = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
